// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity modes,
// legal word widths and the parity helper.
package uart_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

  // Zero padding of narrower words leaves the XOR-reduction unchanged.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ (odd == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Producer-side bundle of the UART transmit engine: word handshake, frame
// configuration and the serial/status outputs.
interface uart_tx_engine_if #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 16
);

  logic [DATA_W-1:0]     p_data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  parity_en;
  logic                  parity_odd;
  logic                  stop2;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output p_data, data_valid, parity_en, parity_odd, stop2, prescale,
    input  data_ready, tx_out, busy, frame_done
  );

  modport slave (
    input  p_data, data_valid, parity_en, parity_odd, stop2, prescale,
    output data_ready, tx_out, busy, frame_done
  );

endinterface

// File: rtl/uart_tx_baud_gen.sv
// Per-bit timer: counts 0..P-1 while a frame is active and flags the final
// cycle of each bit period.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit_end
);

  logic [PRESCALE_W-1:0] r_count;

  assign o_bit_end = i_enable && (r_count == (i_prescale - PRESCALE_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (o_bit_end) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Self-timed UART transmitter: accepts a word over valid/ready, snapshots the
// frame configuration and shifts start, data, parity and stop bits onto tx_out.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_engine_if.slave  bus
);

  localparam int IDX_W = $clog2(DATA_W);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_engine: DATA_W must lie in 5..9");
  end

  tx_state_e             r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_parity_en;
  logic                  r_stop2;
  logic                  r_parity;
  logic                  r_tx;
  logic [PRESCALE_W-1:0] r_prescale;

  logic w_bit_end;
  logic w_last_stop;
  logic w_ready;
  logic w_accept;

  assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_stop_idx == r_stop2);
  assign w_ready     = (r_state == ST_IDLE) || w_last_stop;
  assign w_accept    = bus.data_valid && w_ready;

  assign bus.data_ready = w_ready;
  assign bus.tx_out     = r_tx;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = w_last_stop;

  uart_tx_baud_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_baud (
    .clk        (CLK),
    .rst        (RST),
    .i_clear    (w_accept),
    .i_enable   (r_state != ST_IDLE),
    .i_prescale (r_prescale),
    .o_bit_end  (w_bit_end)
  );

  // tx_out is loaded with the value of the state being entered, so the line
  // changes on the same edge as the state and stays glitch-free.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_tx        <= 1'b1;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_parity_en <= 1'b0;
      r_stop2     <= 1'b0;
      r_parity    <= 1'b0;
      r_prescale  <= PRESCALE_W'(1);
    end else begin
      if (w_accept) begin
        r_shift     <= bus.p_data;
        r_parity_en <= bus.parity_en;
        r_stop2     <= bus.stop2;
        r_parity    <= parity_bit(DATA_W_MAX'(bus.p_data), bus.parity_odd);
        r_prescale  <= (bus.prescale == '0) ? PRESCALE_W'(1) : bus.prescale;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
              if (r_parity_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state    <= ST_STOP;
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state    <= ST_STOP;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop_idx == r_stop2) begin
              r_state <= w_accept ? ST_START : ST_IDLE;
              r_tx    <= ~w_accept;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frames with hand-written line
// patterns plus sequences for back-to-back, snapshot and reset behaviour.
module tb_uart_tx_engine;

  typedef struct {
    logic [7:0]  data;
    logic        parEn;
    logic        parOdd;
    logic        stop2;
    logic [15:0] prescale;
    string       expFrame;
    int          cpb;
    bit          scramble;
  } vector_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  vector_t vectors[6];

  uart_tx_engine_if #(.DATA_W(8), .PRESCALE_W(16)) bus ();

  uart_tx_engine #(
    .DATA_W     (8),
    .PRESCALE_W (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drives the frame inputs in the low phase and lets the next rising edge accept.
  task automatic applyStimulus(input vector_t v, input string tag);
    @(negedge clk);
    bus.p_data     = v.data;
    bus.parity_en  = v.parEn;
    bus.parity_odd = v.parOdd;
    bus.stop2      = v.stop2;
    bus.prescale   = v.prescale;
    bus.data_valid = 1'b1;
    checkOutput($sformatf("%s ready before accept", tag), bus.data_ready, 1'b1);
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic checkFrame(input string expFrame, input int cpb, input bit scramble, input string tag);
    int len;
    logic expBit;
    len = expFrame.len() * cpb;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      expBit = (expFrame[c / cpb] == "1");
      checkOutput($sformatf("%s tx cyc%0d", tag, c + 1), bus.tx_out, expBit);
      checkOutput($sformatf("%s busy cyc%0d", tag, c + 1), bus.busy, 1'b1);
      checkOutput($sformatf("%s done cyc%0d", tag, c + 1), bus.frame_done, c == len - 1);
      checkOutput($sformatf("%s ready cyc%0d", tag, c + 1), bus.data_ready, c == len - 1);
      if (scramble && c == 3) begin
        bus.p_data     = 8'h3C;
        bus.parity_en  = 1'b1;
        bus.parity_odd = 1'b0;
        bus.stop2      = 1'b1;
        bus.prescale   = 16'd3;
      end
    end
    @(negedge clk);
    checkOutput($sformatf("%s idle tx", tag), bus.tx_out, 1'b1);
    checkOutput($sformatf("%s idle busy", tag), bus.busy, 1'b0);
    checkOutput($sformatf("%s idle done", tag), bus.frame_done, 1'b0);
    checkOutput($sformatf("%s idle ready", tag), bus.data_ready, 1'b1);
  endtask

  initial begin
    string b2bFrame;
    logic  expBit;
    vector_t resetVec;

    testsRun    = 0;
    testsFailed = 0;

    vectors[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, "0101001011",   4, 1'b1};
    vectors[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 16'd3, "000111100011", 3, 1'b0};
    vectors[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'd2, "01010010101",  2, 1'b0};
    vectors[3] = '{8'hA5, 1'b1, 1'b1, 1'b0, 16'd2, "01010010111",  2, 1'b0};
    vectors[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 16'd0, "0100000001",   1, 1'b0};
    vectors[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 16'd1, "001101001111", 1, 1'b0};

    rst            = 1'b1;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2      = 1'b0;
    bus.prescale   = 16'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset tx", bus.tx_out, 1'b1);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset done", bus.frame_done, 1'b0);
    checkOutput("reset ready", bus.data_ready, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
      checkFrame(vectors[i].expFrame, vectors[i].cpb, vectors[i].scramble, $sformatf("vec%0d", i));
    end

    // Back-to-back: valid held high, P=1, two stop bits, 0x00 then 0xFF.
    b2bFrame = "0000000001101111111111";
    @(negedge clk);
    bus.p_data     = 8'h00;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2      = 1'b1;
    bus.prescale   = 16'd1;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.p_data = 8'hFF;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      expBit = (b2bFrame[c - 1] == "1");
      checkOutput($sformatf("b2b tx cyc%0d", c), bus.tx_out, expBit);
      checkOutput($sformatf("b2b busy cyc%0d", c), bus.busy, 1'b1);
      checkOutput($sformatf("b2b done cyc%0d", c), bus.frame_done, (c == 11) || (c == 22));
      if (c == 12) bus.data_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("b2b idle busy", bus.busy, 1'b0);
    checkOutput("b2b idle tx", bus.tx_out, 1'b1);

    // Reset during DATA bit 3 of a P=2 frame (bit cell 4, cycles 9-10).
    resetVec = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd2, "", 2, 1'b0};
    applyStimulus(resetVec, "rstmid");
    for (int c = 1; c <= 9; c++) @(negedge clk);
    checkOutput("rstmid data bit3", bus.tx_out, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid tx", bus.tx_out, 1'b1);
    checkOutput("rstmid busy", bus.busy, 1'b0);
    checkOutput("rstmid ready", bus.data_ready, 1'b1);
    checkOutput("rstmid done", bus.frame_done, 1'b0);
    rst = 1'b0;
    resetVec = '{8'h3C, 1'b0, 1'b0, 1'b0, 16'd2, "0001111001", 2, 1'b0};
    applyStimulus(resetVec, "postrst");
    checkFrame(resetVec.expFrame, resetVec.cpb, 1'b0, "postrst");

    // Reset wins over an accept on the same edge.
    @(negedge clk);
    rst            = 1'b1;
    bus.data_valid = 1'b1;
    @(negedge clk);
    checkOutput("rstprio busy", bus.busy, 1'b0);
    checkOutput("rstprio tx", bus.tx_out, 1'b1);
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstprio stays idle", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
